// File: rtl/tcb_pkg.sv
// Shared TCB definitions: select-width helper and the response-pipeline entry.
package tcb_pkg;

    // Widest select field any decoder needs (up to 16 downstream ports)
    localparam int SEL_MAX_W = 4;

    // Bits needed to index bn ports; never narrower than one bit
    function automatic int tcb_sel_w(input int bn);
        return (bn <= 2) ? 1 : $clog2(bn);
    endfunction

    // One response slot: read pending, error pending, and the port it came from
    typedef struct packed {
        logic                 vld;
        logic                 err;
        logic [SEL_MAX_W-1:0] sel;
    } tcb_ent_t;

endpackage

// File: rtl/tcb_dec_pipe.sv
// Fixed-length delay line for response-routing entries.
// Entry DLY-1 is the one whose read data is on the downstream bus this cycle.
module tcb_dec_pipe #(
    parameter int  DLY   = 1,
    parameter type ENT_T = logic
) (
    input  logic clk,
    input  logic rst,
    input  ENT_T din,
    output ENT_T dout
);

    ENT_T ent_p [DLY];

    // Shift one entry per cycle; reset drops every in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) begin
                ent_p[i] <= '0;
            end
        end else begin
            ent_p[0] <= din;
            for (int i = 1; i < DLY; i++) begin
                ent_p[i] <= ent_p[i-1];
            end
        end
    end

    assign dout = ent_p[DLY-1];

endmodule

// File: rtl/tcb_dec.sv
// TCB address decoder: one upstream port fanned out to BN downstream ports.
// Requests route combinationally; read data returns DLY cycles after the
// handshake and is steered by an entry that travelled the delay line.
// Optional feature macro TCB_DEC_ERR_EN: unmatched requests are acknowledged
// locally and answered with s_err; otherwise they fall through to port BN-1.
module tcb_dec
    import tcb_pkg::*;
#(
    parameter int                   AW  = 32,
    parameter int                   DW  = 32,
    parameter int                   SW  = DW/8,
    parameter int                   BN  = 2,
    parameter int                   DLY = 1,
    parameter logic [BN-1:0][AW-1:0] DAM = '1,
    parameter logic [BN-1:0][AW-1:0] DAD = '0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef TCB_DEC_ERR_EN
    output logic                   s_err,
`endif
    input  logic                   s_vld,
    input  logic                   s_wen,
    input  logic [AW-1:0]          s_adr,
    input  logic [SW-1:0]          s_ben,
    input  logic [DW-1:0]          s_wdt,
    output logic [DW-1:0]          s_rdt,
    output logic                   s_rdy,
    output logic [BN-1:0]          m_vld,
    output logic [BN-1:0]          m_wen,
    output logic [BN-1:0][AW-1:0]  m_adr,
    output logic [BN-1:0][SW-1:0]  m_ben,
    output logic [BN-1:0][DW-1:0]  m_wdt,
    input  logic [BN-1:0][DW-1:0]  m_rdt,
    input  logic [BN-1:0]          m_rdy
);

    localparam int SEL_W = tcb_sel_w(BN);

    logic             hit;
    logic [SEL_W-1:0] sel;
    logic             xfer;
    tcb_ent_t         ent_p0;
    tcb_ent_t         ent_pd;

    // Address match: scan from the top so the lowest matching port wins
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = BN-1; i >= 0; i--) begin
            if ((s_adr & DAM[i]) == DAD[i]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
`ifndef TCB_DEC_ERR_EN
        if (!hit) sel = SEL_W'(BN-1);
`endif
    end

    // Request path: only the selected port sees s_vld, and its ready comes back
    always_comb begin
        m_vld = '0;
        s_rdy = 1'b0;
        for (int i = 0; i < BN; i++) begin
            if (sel == SEL_W'(i)) begin
                m_vld[i] = s_vld;
                s_rdy    = m_rdy[i];
            end
        end
`ifdef TCB_DEC_ERR_EN
        if (!hit) begin
            m_vld = '0;
            s_rdy = 1'b1;
        end
`endif
    end

    // Request payload is shared by all ports; m_vld alone qualifies it
    assign m_wen = {BN{s_wen}};
    assign m_adr = {BN{s_adr}};
    assign m_ben = {BN{s_ben}};
    assign m_wdt = {BN{s_wdt}};

    assign xfer = s_vld & s_rdy;

    // Build this cycle's response entry; idle cycles push an empty slot
    always_comb begin
        ent_p0     = '0;
        ent_p0.sel = SEL_MAX_W'(sel);
`ifdef TCB_DEC_ERR_EN
        ent_p0.vld = xfer & ~s_wen & hit;
        ent_p0.err = xfer & ~hit;
`else
        ent_p0.vld = xfer & ~s_wen;
        ent_p0.err = 1'b0;
`endif
    end

    // ---- stage boundary: request cycle -> response cycle (DLY later) ----
    tcb_dec_pipe #(
        .DLY   (DLY),
        .ENT_T (tcb_ent_t)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (ent_p0),
        .dout (ent_pd)
    );

    // Response mux: steer the port named by the matured entry, quiet in reset
    always_comb begin
        s_rdt = '0;
        if (ent_pd.vld & ~ent_pd.err & ~rst) begin
            for (int i = 0; i < BN; i++) begin
                if (ent_pd.sel == SEL_MAX_W'(i)) s_rdt = m_rdt[i];
            end
        end
    end

`ifdef TCB_DEC_ERR_EN
    assign s_err = ent_pd.err & ~rst;
`endif

endmodule

// File: tb/tb_tcb_dec.sv
// Directed bench for tcb_dec: BN=2, DLY=1, port 0 at 0x0xxx_xxxx, port 1 at 0x4xxx_xxxx.
module tb_tcb_dec;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int BN = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_vld;
    logic                  s_wen;
    logic [AW-1:0]         s_adr;
    logic [SW-1:0]         s_ben;
    logic [DW-1:0]         s_wdt;
    logic [DW-1:0]         s_rdt;
    logic                  s_rdy;
    logic [BN-1:0]         m_vld;
    logic [BN-1:0]         m_wen;
    logic [BN-1:0][AW-1:0] m_adr;
    logic [BN-1:0][SW-1:0] m_ben;
    logic [BN-1:0][DW-1:0] m_wdt;
    logic [BN-1:0][DW-1:0] m_rdt;
    logic [BN-1:0]         m_rdy;
`ifdef TCB_DEC_ERR_EN
    logic                  s_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    tcb_dec #(
        .AW  (AW),
        .DW  (DW),
        .SW  (SW),
        .BN  (BN),
        .DLY (1),
        .DAM ({32'hC000_0000, 32'hC000_0000}),
        .DAD ({32'h4000_0000, 32'h0000_0000})
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef TCB_DEC_ERR_EN
        .s_err (s_err),
`endif
        .s_vld (s_vld),
        .s_wen (s_wen),
        .s_adr (s_adr),
        .s_ben (s_ben),
        .s_wdt (s_wdt),
        .s_rdt (s_rdt),
        .s_rdy (s_rdy),
        .m_vld (m_vld),
        .m_wen (m_wen),
        .m_adr (m_adr),
        .m_ben (m_ben),
        .m_wdt (m_wdt),
        .m_rdt (m_rdt),
        .m_rdy (m_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        s_vld = 1'b0;
        s_wen = 1'b0;
        s_adr = '0;
        s_ben = '0;
        s_wdt = '0;
        m_rdy = 2'b11;
        m_rdt = {32'h2222_2222, 32'h1111_1111};

        // Reset: response quiet, request path still live
        tick();
        tick();
        chk("rst_rdt", s_rdt, 32'h0);
        chk("rst_mvld_idle", 32'(m_vld), 32'h0);
        s_vld = 1'b1;
        #1;
        chk("rst_mvld_live", 32'(m_vld), 32'h1);
        chk("rst_rdy_live", 32'(s_rdy), 32'h1);
        tick();
        chk("rst_rdt_after_xfer", s_rdt, 32'h0);
        s_vld = 1'b0;
        rst   = 1'b0;
        tick();
        chk("post_rst_rdt", s_rdt, 32'h0);

        // Single read to port 0
        m_rdt[0] = 32'hAAAA_5555;
        s_vld = 1'b1;
        s_adr = 32'h0000_0010;
        #1;
        chk("rd0_mvld", 32'(m_vld), 32'h1);
        chk("rd0_rdy", 32'(s_rdy), 32'h1);
        tick();
        s_vld = 1'b0;
        #1;
        chk("rd0_rdt", s_rdt, 32'hAAAA_5555);
        tick();
        chk("rd0_rdt_once", s_rdt, 32'h0);

        // Back-to-back reads to different ports
        m_rdt = {32'h2222_2222, 32'h1111_1111};
        s_vld = 1'b1;
        s_adr = 32'h0000_0000;
        #1;
        chk("b2b_mvld_a", 32'(m_vld), 32'h1);
        tick();
        s_adr = 32'h4000_0000;
        #1;
        chk("b2b_mvld_b", 32'(m_vld), 32'h2);
        chk("b2b_rdt_a", s_rdt, 32'h1111_1111);
        tick();
        s_vld = 1'b0;
        #1;
        chk("b2b_rdt_b", s_rdt, 32'h2222_2222);
        tick();
        chk("b2b_rdt_end", s_rdt, 32'h0);

        // Read stalled by port 1 for three cycles
        m_rdy = 2'b01;
        s_vld = 1'b1;
        s_adr = 32'h4000_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", 32'(s_rdy), 32'h0);
            chk("stall_mvld", 32'(m_vld), 32'h2);
            tick();
            chk("stall_rdt", s_rdt, 32'h0);
        end
        m_rdy = 2'b11;
        #1;
        chk("stall_rdy_go", 32'(s_rdy), 32'h1);
        tick();
        s_vld = 1'b0;
        #1;
        chk("stall_rdt_rsp", s_rdt, 32'h2222_2222);
        tick();
        chk("stall_rdt_once", s_rdt, 32'h0);

        // Write to port 0: fields broadcast, no response
        s_vld = 1'b1;
        s_wen = 1'b1;
        s_adr = 32'h0000_0008;
        s_wdt = 32'hDEAD_BEEF;
        s_ben = 4'b0011;
        #1;
        chk("wr_mvld", 32'(m_vld), 32'h1);
        chk("wr_wen", 32'(m_wen), 32'h3);
        chk("wr_adr0", m_adr[0], 32'h0000_0008);
        chk("wr_wdt0", m_wdt[0], 32'hDEAD_BEEF);
        chk("wr_ben0", 32'(m_ben[0]), 32'h3);
        chk("wr_wdt1", m_wdt[1], 32'hDEAD_BEEF);
        tick();
        s_vld = 1'b0;
        s_wen = 1'b0;
        #1;
        chk("wr_rdt", s_rdt, 32'h0);
        tick();

        // Unmatched address
        s_vld = 1'b1;
        s_adr = 32'h8000_0000;
        #1;
        chk("nomatch_rdy", 32'(s_rdy), 32'h1);
`ifdef TCB_DEC_ERR_EN
        chk("nomatch_mvld", 32'(m_vld), 32'h0);
        tick();
        s_vld = 1'b0;
        #1;
        chk("nomatch_err", 32'(s_err), 32'h1);
        chk("nomatch_rdt", s_rdt, 32'h0);
`else
        chk("nomatch_mvld", 32'(m_vld), 32'h2);
        tick();
        s_vld = 1'b0;
        #1;
        chk("nomatch_rdt", s_rdt, 32'h2222_2222);
`endif
        tick();

        // Reset right after a read handshake discards the response
        s_vld = 1'b1;
        s_adr = 32'h0000_0000;
        tick();
        s_vld = 1'b0;
        rst   = 1'b1;
        #1;
        chk("rstrd_rdt_in_rst", s_rdt, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstrd_rdt_after", s_rdt, 32'h0);
        tick();
        chk("rstrd_rdt_later", s_rdt, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
